// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the MemoryUnit port shared by the arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              eu_req;
    logic              eu_we;
    logic [ADDR_W-1:0] eu_addr;
    logic [DATA_W-1:0] eu_wdata;
    logic              eu_ack;
    logic [DATA_W-1:0] eu_rdata;
    logic              eu_hold;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_lock;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        owner;

    modport slave (
        input  eu_req, eu_we, eu_addr, eu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  mem_rdata,
        output eu_ack, eu_rdata, eu_hold,
        output ld_ack, ld_rdata,
        output mem_addr, mem_wdata, mem_we,
        output owner
    );

    modport master (
        output eu_req, eu_we, eu_addr, eu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output mem_rdata,
        input  eu_ack, eu_rdata, eu_hold,
        input  ld_ack, ld_rdata,
        input  mem_addr, mem_wdata, mem_we,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single MemoryUnit port between the ExecutionUnit and the loader/debug port:
// EU has fixed priority, the loader has a starvation guard and an exclusive lock mode.
//
// state | meaning
// IDLE  | arbitrate; latch winner's command into mem_* registers and set owner
// ISSUE | mem_we pulses for this cycle; mem_rdata captured into owner's rdata on exit
// RESP  | owner's ack pulses; mem_addr held; owner cleared on exit
module mem_port_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int LD_STARVE_MAX = 4
) (
    input  logic              PLClock,
    input  logic              PLResetN,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = ($clog2(LD_STARVE_MAX + 1) > 0) ? $clog2(LD_STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(LD_STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starveCnt;
    logic             euEligible;
    logic             ldWins;

    // Under lock the EU is simply not a candidate; otherwise the loader only
    // beats a pending EU request once it has been starved long enough.
    always_comb begin
        euEligible = bus.eu_req && !bus.ld_lock;
        ldWins     = bus.ld_req && (bus.ld_lock || !bus.eu_req || (starveCnt == STARVE_MAX));
    end

    always_ff @(posedge PLClock or negedge PLResetN) begin
        if (!PLResetN) begin
            state         <= IDLE;
            starveCnt     <= '0;
            bus.eu_ack    <= 1'b0;
            bus.ld_ack    <= 1'b0;
            bus.eu_hold   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.eu_rdata  <= {DATA_W{1'b0}};
            bus.ld_rdata  <= {DATA_W{1'b0}};
            bus.owner     <= 2'b00;
        end else begin
            bus.eu_hold <= bus.ld_lock;
            bus.eu_ack  <= 1'b0;
            bus.ld_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    bus.owner <= 2'b00;
                    if (ldWins) begin
                        state         <= ISSUE;
                        bus.owner     <= 2'b10;
                        bus.mem_we    <= bus.ld_we;
                        bus.mem_addr  <= bus.ld_addr;
                        bus.mem_wdata <= bus.ld_wdata;
                        starveCnt     <= '0;
                    end else if (euEligible) begin
                        state         <= ISSUE;
                        bus.owner     <= 2'b01;
                        bus.mem_we    <= bus.eu_we;
                        bus.mem_addr  <= bus.eu_addr;
                        bus.mem_wdata <= bus.eu_wdata;
                        if (bus.ld_req && (starveCnt != STARVE_MAX)) begin
                            starveCnt <= starveCnt + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    state      <= RESP;
                    bus.mem_we <= 1'b0;
                    if (bus.owner == 2'b10) begin
                        bus.ld_rdata <= bus.mem_rdata;
                        bus.ld_ack   <= 1'b1;
                    end else begin
                        bus.eu_rdata <= bus.mem_rdata;
                        bus.eu_ack   <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    bus.owner <= 2'b00;
                end
                default: begin
                    state      <= IDLE;
                    bus.owner  <= 2'b00;
                    bus.mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
